// File: rtl/example.sv
// rtl/example.sv - elaboration-time bit gather (compress) with one-cycle registered output
//
// Purpose:
//   Picks the data_in bits selected by PATTERN and packs them densely into
//   data_out, lowest selected bit first. The selection is a parameter, so the
//   gather reduces to fixed wiring followed by a single output register stage.
//
// Parameters:
//   PATTERN    32-bit selection mask; bit k = 1 keeps data_in[k]. Bits at or
//              above WIDTH are ignored.
//   WIDTH      data_in width in bits, 1..32.
//   OUT_WIDTH  derived: number of kept bits (minimum 1).
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset; wins over in_valid
//   in_valid   data_in is valid this cycle
//   data_in    source word [WIDTH-1:0]
//   out_valid  data_out was loaded by the previous edge
//   data_out   gathered word [OUT_WIDTH-1:0]; holds its value while idle

module example #(
  parameter logic [31:0] PATTERN = 32'h0000_0000,
  parameter int          WIDTH   = 32,
  // Bits of PATTERN that fall inside data_in.
  localparam logic [31:0] WIDTH_MASK =
    (WIDTH >= 32) ? 32'hFFFF_FFFF :
    (WIDTH < 1)   ? 32'h0000_0000 :
                    ((32'd1 << WIDTH) - 32'd1),
  localparam logic [31:0] MASK      = PATTERN & WIDTH_MASK,
  localparam int          SET_BITS  = $countones(MASK),
  localparam int          OUT_WIDTH = (SET_BITS == 0) ? 1 : SET_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] data_out
);

  // Position of the n-th (0-based) set bit of m; only ever called with
  // n < $countones(m), so the fallback value is never used.
  function automatic int nth_set(input logic [31:0] m, input int n);
    int seen;
    int pos;
    seen = 0;
    pos  = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        if (seen == n) pos = i;
        seen = seen + 1;
      end
    end
    return pos;
  endfunction

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("example: WIDTH=%0d outside legal range 1..32", WIDTH);
    end
  endgenerate

  logic [OUT_WIDTH-1:0] gathered;

  // Each output bit is a fixed wire from one input bit; no mask logic remains
  // after elaboration.
  generate
    if (SET_BITS == 0) begin : g_empty
      assign gathered = '0;
    end else begin : g_gather
      for (genvar j = 0; j < OUT_WIDTH; j++) begin : g_bit
        localparam int SRC = nth_set(MASK, j);
        assign gathered[j] = data_in[SRC];
      end
    end
  endgenerate

  // Bits not selected by the mask are intentionally dropped.
  logic unused_in_bits;
  assign unused_in_bits = ^data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= gathered;
      end
    end
  end

endmodule

// File: tb/tb_example.sv
// tb/tb_example.sv - directed self-checking bench for example across several PATTERN/WIDTH settings

module tb_example;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;

  logic [4:0] d5;
  logic [9:0] d10;
  logic [3:0] d4;
  logic [5:0] d6;

  logic       v5, v10, v_ones, v_zero, v_hi;
  logic [2:0] o5;
  logic [6:0] o10;
  logic [3:0] o_ones;
  logic [0:0] o_zero;
  logic [1:0] o_hi;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // PATTERN 5'b10101 -> keeps bits 0,2,4
  example #(.PATTERN(32'h0000_0015), .WIDTH(5)) u_p5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(d5),
    .out_valid(v5), .data_out(o5));

  // PATTERN 10'b1110001111 -> keeps bits 0,1,2,3,7,8,9
  example #(.PATTERN(32'h0000_038F), .WIDTH(10)) u_p10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(d10),
    .out_valid(v10), .data_out(o10));

  // All-ones PATTERN on a 4-bit input: pass-through
  example #(.PATTERN(32'hFFFF_FFFF), .WIDTH(4)) u_ones (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(d4),
    .out_valid(v_ones), .data_out(o_ones));

  // Zero PATTERN: 1-bit output stuck at 0
  example #(.PATTERN(32'h0000_0000), .WIDTH(4)) u_zero (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(d4),
    .out_valid(v_zero), .data_out(o_zero));

  // PATTERN bits above WIDTH ignored: only bits 4,5 survive on a 6-bit input
  example #(.PATTERN(32'hFFFF_FFF0), .WIDTH(6)) u_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(d6),
    .out_valid(v_hi), .data_out(o_hi));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    d5  = 5'b11111;
    d10 = 10'h3FF;
    d4  = 4'hF;
    d6  = 6'h3F;

    // Reset with in_valid high: word discarded
    step();
    check("rst_v5",    {31'd0, v5},  32'd0);
    check("rst_o5",    {29'd0, o5},  32'd0);
    check("rst_v10",   {31'd0, v10}, 32'd0);
    check("rst_o10",   {25'd0, o10}, 32'd0);
    check("rst_oones", {28'd0, o_ones}, 32'd0);

    // First word after release: 1-cycle latency
    rst = 1'b0;
    d5  = 5'b11010;
    d10 = 10'b1010110011;
    d4  = 4'b1011;
    d6  = 6'b101010;
    step();
    check("p5_v",    {31'd0, v5},  32'd1);
    check("p5_o",    {29'd0, o5},  32'b100);
    check("p10_v",   {31'd0, v10}, 32'd1);
    check("p10_o",   {25'd0, o10}, 32'b1010011);
    check("ones_o",  {28'd0, o_ones}, 32'b1011);
    check("ones_v",  {31'd0, v_ones}, 32'd1);
    check("zero_o",  {31'd0, o_zero}, 32'd0);
    check("zero_v",  {31'd0, v_zero}, 32'd1);
    check("hi_o",    {30'd0, o_hi}, 32'b10);

    // Back-to-back words, one per cycle
    d10 = 10'h3FF; d4 = 4'b0110; d6 = 6'b011111;
    step();
    check("bb1_o10", {25'd0, o10}, 32'b1111111);
    check("bb1_v10", {31'd0, v10}, 32'd1);
    check("bb1_ones", {28'd0, o_ones}, 32'b0110);
    check("bb1_hi",  {30'd0, o_hi}, 32'b01);
    d10 = 10'h000; d4 = 4'hF;
    step();
    check("bb2_o10", {25'd0, o10}, 32'b0000000);
    check("bb2_v10", {31'd0, v10}, 32'd1);
    check("bb2_zero", {31'd0, o_zero}, 32'd0);
    d10 = 10'b0000001000;
    step();
    check("bb3_o10", {25'd0, o10}, 32'b0001000);
    d10 = 10'b0001110000;
    step();
    check("bb4_o10", {25'd0, o10}, 32'b0000000);
    d10 = 10'b1000000001;
    step();
    check("bb5_o10", {25'd0, o10}, 32'b1000001);

    // Idle: out_valid drops, data_out holds last word
    in_valid = 1'b0;
    d10 = 10'h3FF;
    step();
    check("idle1_v10", {31'd0, v10}, 32'd0);
    check("idle1_o10", {25'd0, o10}, 32'b1000001);
    step();
    check("idle2_v10", {31'd0, v10}, 32'd0);
    check("idle2_o10", {25'd0, o10}, 32'b1000001);

    // Mid-stream reset drops the in-flight word
    in_valid = 1'b1;
    d10 = 10'h3FF;
    step();
    check("pre_o10", {25'd0, o10}, 32'b1111111);
    rst = 1'b1;
    d10 = 10'b1010110011;
    step();
    check("mrst_v10", {31'd0, v10}, 32'd0);
    check("mrst_o10", {25'd0, o10}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_idle_v10", {31'd0, v10}, 32'd0);
    check("post_idle_o10", {25'd0, o10}, 32'd0);
    in_valid = 1'b1;
    d10 = 10'b1010110011;
    step();
    check("post_v10", {31'd0, v10}, 32'd1);
    check("post_o10", {25'd0, o10}, 32'b1010011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
